// File: rtl/multiword_add_sequencer.sv
// Multi-precision add sequencer: streams LSB-first byte pairs through an external
// 8-bit adder, chains the carry in a register and emits a handshaked result stream.
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_cin,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_last,
  output logic       out_cout,
  output logic       out_ovf
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [7:0]       sum_q, sum_d;
  logic             last_q, last_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             at_last;

  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic signed_ovf(input logic signed [7:0] a,
                                      input logic signed [7:0] b,
                                      input logic signed [7:0] s);
    return (a[7] == b[7]) && (s[7] != a[7]);
  endfunction

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign at_last  = (idx_q == LAST_IDX);

  assign add_a   = in_a;
  assign add_b   = in_b;
  assign add_cin = (idx_q == '0) ? in_cin : carry_q;

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (clr) begin
      idx_d   = '0;
      carry_d = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      sum_d   = add_sum;
      valid_d = 1'b1;
      last_d  = at_last;
      carry_d = add_cout;
      if (at_last) begin
        cout_d = add_cout;
        ovf_d  = signed_ovf(in_a, in_b, add_sum);
        idx_d  = '0;
      end else begin
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        idx_d  = idx_q + IDX_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= 8'h00;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_last  = last_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with a behavioural 8-bit adder and a
// full-width reference sum feeding an expected-byte queue.
module tb_multiword_add_sequencer;

  localparam int W  = 4;
  localparam int OW = 8 * W;

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_cin = 1'b0;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_last, out_cout, out_ovf;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  multiword_add_sequencer #(.WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // The team's ripple-carry adder, modelled behaviourally.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t calc(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                input logic cin, input int k);
    logic [OW:0] full;
    exp_t e;
    full   = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
    e.sum  = full[8*k +: 8];
    e.last = (k == W - 1);
    e.cout = e.last ? full[OW] : 1'b0;
    e.ovf  = e.last ? ((a[OW-1] == b[OW-1]) && (full[OW-1] != a[OW-1])) : 1'b0;
    return e;
  endfunction

  // One clock: compare any output transfer before the edge, record an accept at it.
  task automatic cycle(input exp_t e, input bit push, output bit acc);
    exp_t got;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(out_sum), 32'hFFFF_FFFF);
      end else begin
        got = sb.pop_front();
        chk("out_byte", 32'({out_sum, out_last, out_cout, out_ovf}), 32'(got));
      end
    end
    acc = push && in_valid && in_ready && !clr;
    @(posedge clk);
    if (acc) sb.push_back(e);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic ci,
                           input exp_t e);
    bit acc = 1'b0;
    in_a = a; in_b = b; in_cin = ci; in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) cycle(e, 1'b1, acc);
    if (!acc) chk("accept_timeout", 32'(in_ready), 32'd1);
    else      chk("latency_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                        input logic cin, input bit stall);
    int   c0;
    exp_t e;
    c0 = cyc;
    for (int k = 0; k < W; k++) begin
      e = calc(a, b, cin, k);
      send_byte(a[8*k +: 8], b[8*k +: 8], (k == 0) ? cin : 1'($urandom), e);
      if (stall && k == 0) begin
        out_ready = 1'b0;
        in_a = a[15:8]; in_b = b[15:8]; in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_hold_sum", 32'(out_sum), 32'(e.sum));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    end
    if (!stall) chk("op_cycles", 32'(cyc - c0), 32'(W));
  endtask

  initial begin
    exp_t e;
    bit   acc;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_out_cout",  32'(out_cout),  32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    in_cin = 1'b1; #1;
    chk("idle_add_cin",  32'(add_cin),   32'd1);
    in_cin = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(32'h1122_33F4, 32'h55EE_77CC, 1'b1, 1'b1);

    // Abort mid-operation with a byte presented in the same cycle.
    send_byte(8'h01, 8'h01, 1'b0, calc(32'h0101_0101, 32'h0101_0101, 1'b0, 0));
    send_byte(8'h01, 8'h01, 1'b0, calc(32'h0101_0101, 32'h0101_0101, 1'b0, 1));
    in_a = 8'h01; in_b = 8'h01; in_valid = 1'b1; clr = 1'b1;
    cycle(calc(32'h0101_0101, 32'h0101_0101, 1'b0, 2), 1'b1, acc);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);

    // Asynchronous reset after byte 2 of an operation.
    for (int k = 0; k < 3; k++)
      send_byte(8'(32'h1234_5678 >> (8*k)), 8'(32'h1111_1111 >> (8*k)), 1'b0,
                calc(32'h1234_5678, 32'h1111_1111, 1'b0, k));
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_sum",   32'(out_sum),   32'd0);
    chk("mrst_flags",     32'({out_last, out_cout, out_ovf}), 32'd0);
    chk("mrst_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++)
      run_op(OW'($urandom), OW'($urandom), 1'($urandom), 1'b0);

    e = '0;
    for (int d = 0; d < 3; d++) cycle(e, 1'b0, acc);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Multi-precision add controller that sits directly upstream of the team's 8-bit ripple-carry adder. It accepts two wide operands as a stream of byte pairs, least-significant byte first, and drives each pair into the adder's `a`/`b`/`cin` inputs. It takes the adder's `sum`/`cout` back and chains the carry between bytes in a register. It emits the result as a byte stream with valid/ready handshakes, flagging the final carry and signed overflow on the last byte.

## Interface
- `WORDS`, default 4: bytes per operand; legal range 2..16. The default gives a 32-bit add.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous abort; returns the block to the idle state.
- `in_valid` input 1: a byte pair is presented.
- `in_ready` output 1: the block can accept a byte pair.
- `in_a` input 8: operand A byte.
- `in_b` input 8: operand B byte.
- `in_cin` input 1: carry-in for the whole operation; used only on byte 0.
- `add_a` output 8: to adder `a`.
- `add_b` output 8: to adder `b`.
- `add_cin` output 1: to adder `cin`.
- `add_sum` input 8: from adder `sum`.
- `add_cout` input 1: from adder `cout`.
- `out_valid` output 1: result byte is valid.
- `out_ready` input 1: the consumer accepts the result byte.
- `out_sum` output 8: result byte.
- `out_last` output 1: the result byte is byte `WORDS-1`.
- `out_cout` output 1: final carry-out; meaningful only when `out_last` is high.
- `out_ovf` output 1: signed overflow of the full-width add; meaningful only when `out_last` is high.

## Operation
- **Adder drive (combinational):**
  - `add_a = in_a` and `add_b = in_b`.
  - `add_cin = in_cin` when `idx == 0`, else `carry_q`.
  - The adder is purely combinational, so `add_sum`/`add_cout` are valid in the same cycle.
- **State:**
  - `idx`: byte index, width `clog2(WORDS)`.
  - `carry_q`: chained carry register.
  - One-deep output register: `out_sum`, `out_last`, `out_cout`, `out_ovf`, `out_valid`.
- **Handshake:**
  - `in_ready = !out_valid || out_ready`.
  - Input accept occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- **On input accept:**
  - `out_sum <= add_sum` and `out_valid <= 1`.
  - `out_last <= (idx == WORDS-1)`.
  - `carry_q <= add_cout`.
  - If `idx == WORDS-1`:
    - `out_cout <= add_cout`.
    - `out_ovf <= (in_a[7] == in_b[7]) && (add_sum[7] != in_a[7])`.
    - `idx <= 0`, wrapping for the next operation.
  - Otherwise `idx <= idx + 1`, with `out_cout` and `out_ovf` cleared to 0.
- **Output transfer without a new accept:** `out_valid <= 0`.
- **Simultaneous transfer and accept:** the register reloads and `out_valid` stays 1, giving full throughput of one byte per cycle.
- **Phases, derived from `idx`:** IDLE (`idx == 0`) → RUN (`0 < idx`) → IDLE after the byte at `idx == WORDS-1` is accepted. No separate FSM encoding is required beyond `idx`.
- **`clr`:**
  - Forces `idx = 0`, `carry_q = 0`, `out_valid = 0`, and clears `out_last`/`out_cout`/`out_ovf`.
  - It has priority over a same-cycle input accept; that accept is discarded.
- **Input stability:** `in_a`, `in_b` and `in_cin` must stay stable while `in_valid` is high and `in_ready` is low.

## Timing
- **Reset values (on `rst_n` low, asynchronous):**
  - `idx = 0`, `carry_q = 0`.
  - `out_valid = 0`, `out_sum = 0x00`, `out_last = 0`, `out_cout = 0`, `out_ovf = 0`.
  - `in_ready = 1` follows from `out_valid = 0`.
- **Latency:** 1 cycle from input accept to `out_valid` for the corresponding byte.
- **Throughput:**
  - One byte per cycle with `out_ready` held high.
  - A full operation takes `WORDS` accept cycles.
  - Back-to-back operations need no bubble.
- **Back-pressure:** when `out_ready` is low and `out_valid` is high, `in_ready` is low and every output holds steady.
- **Reset mid-operation:** the partial result is lost. The next accepted byte is treated as byte 0 and uses `in_cin`.
- **Combinational paths:**
  - `in_a`/`in_b` → `add_*` (into the adder) → `add_sum` → output register D.
  - `out_ready` → `in_ready`.
  - No combinational path from `in_valid` to `in_ready`.

## Test plan
- **Carry ripple across bytes:** `WORDS=4`, A=0xFFFFFFFF, B=0x00000001, cin=0, `out_ready=1`.
  - Out bytes 00,00,00,00, each one cycle after its accept.
  - Last byte has `out_last=1`, `out_cout=1`, `out_ovf=0`.
- **Carry-in on byte 0 only:** A=0x000000FF, B=0x00000000, cin=1.
  - Bytes 00,01,00,00 with `out_cout=0`.
  - `in_cin` toggled on bytes 1–3 has no effect.
- **Signed overflow:** A=0x7FFFFFFF, B=0x00000001.
  - Bytes 00,00,00,80 with `out_ovf=1` and `out_cout=0` on the last byte.
  - Then A=0x80000000, B=0x80000000 gives `out_cout=1`, `out_ovf=1`.
- **Back-pressure:** hold `out_ready=0` for 3 cycles after the first byte.
  - `in_ready=0` throughout and `out_sum` is stable.
  - On release, all bytes are delivered in order with no loss or duplication.
- **Abort:** assert `clr` after byte 1 of an operation (A=0x01010101, B=0x01010101) while a byte is also presented.
  - `out_valid` drops next cycle and the presented byte is discarded.
  - A new op A=0x00000003, B=0x00000004 then yields 07,00,00,00.
- **Reset mid-operation:** pulse `rst_n` low asynchronously after byte 2.
  - All outputs take their reset values immediately.
  - The next operation starts at byte 0 and produces correct results.
